// File: rtl/spi_ctrl_pkg.sv
// Shared types for the SPI master controller: FSM states, SPI mode and the
// per-transfer control fields captured when a command is accepted.
package spi_ctrl_pkg;

  typedef enum logic [2:0] {
    IDLE     = 3'd0,
    CS_GAP   = 3'd1,
    CS_SETUP = 3'd2,
    SHIFT    = 3'd3,
    CS_HOLD  = 3'd4
  } state_t;

  typedef struct packed {
    logic cpol;
    logic cpha;
  } spi_mode_t;

  typedef struct packed {
    spi_mode_t mode;
    logic      last;
  } cmd_ctrl_t;

endpackage

// File: rtl/spi_clk_div.sv
// Half-period tick generator: reloads on start and after every tick, so a
// tick fires once every (div_i+1) enabled cycles.
module spi_clk_div #(
  parameter int DIV_W = 8
) (
  input  logic             clk_i,
  input  logic             rst_ni,
  input  logic             start_i,
  input  logic             en_i,
  input  logic [DIV_W-1:0] div_i,
  output logic             tick_o
);

  localparam logic [DIV_W-1:0] CNT_ZERO = {DIV_W{1'b0}};
  localparam logic [DIV_W-1:0] CNT_ONE  = {{(DIV_W-1){1'b0}}, 1'b1};

  logic [DIV_W-1:0] cnt_r;

  assign tick_o = en_i && (cnt_r == CNT_ZERO);

  // Half-period down-counter
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      cnt_r <= CNT_ZERO;
    end else if (start_i || tick_o) begin
      cnt_r <= div_i;
    end else if (en_i) begin
      cnt_r <= cnt_r - CNT_ONE;
    end else begin
      cnt_r <= cnt_r;
    end
  end

endmodule

// File: rtl/spi_master_ctrl.sv
// Single-word SPI master: accepts commands, sequences chip select, SCLK and
// MOSI for all CPOL/CPHA modes and returns the word sampled from MISO.
module spi_master_ctrl
  import spi_ctrl_pkg::*;
#(
  parameter int  DATA_W = 8,
  parameter int  DIV_W  = 8,
  parameter int  NUM_CS = 2,
  localparam int CS_W   = (NUM_CS > 1) ? $clog2(NUM_CS) : 1
) (
  input  logic              clk_i,
  input  logic              rst_ni,
  input  logic              cmd_valid_i,
  output logic              cmd_ready_o,
  input  logic [DATA_W-1:0] cmd_data_i,
  input  logic [CS_W-1:0]   cmd_cs_i,
  input  logic              cmd_last_i,
  input  logic              cfg_cpol_i,
  input  logic              cfg_cpha_i,
  input  logic [DIV_W-1:0]  cfg_div_i,
  output logic              rsp_valid_o,
  output logic [DATA_W-1:0] rsp_data_o,
  output logic              busy_o,
  output logic              sclk_o,
  output logic              mosi_o,
  input  logic              miso_i,
  output logic [NUM_CS-1:0] cs_no
);

  localparam int                EC_W      = $clog2(2 * DATA_W);
  localparam logic [EC_W-1:0]   EC_ZERO   = {EC_W{1'b0}};
  localparam logic [EC_W-1:0]   LAST_EDGE = EC_W'(2 * DATA_W - 1);
  localparam logic [NUM_CS-1:0] CS_NONE   = {NUM_CS{1'b1}};

  // Out-of-range indices match no bit, leaving every select released.
  function automatic logic [NUM_CS-1:0] cs_decode(input logic [CS_W-1:0] idx);
    logic [NUM_CS-1:0] cs_n;
    cs_n = CS_NONE;
    for (int i = 0; i < NUM_CS; i++) begin
      if (idx == CS_W'(i)) begin
        cs_n[i] = 1'b0;
      end
    end
    return cs_n;
  endfunction

  state_t            state_r;
  cmd_ctrl_t         ctrl_r;
  logic [CS_W-1:0]   cs_idx_r;
  logic [DIV_W-1:0]  div_r;
  logic [DATA_W-1:0] tx_r;
  logic [DATA_W-1:0] rx_r;
  logic [EC_W-1:0]   edge_cnt_r;
  logic              cs_held_r;
  logic              gap_setup_r;
  logic              ready_r;
  logic              busy_r;
  logic              rsp_valid_r;
  logic [DATA_W-1:0] rsp_data_r;
  logic              sclk_r;
  logic              mosi_r;
  logic [NUM_CS-1:0] cs_n_r;

  logic              accept_s;
  logic              tick_s;
  logic [DIV_W-1:0]  div_sel_s;
  logic              sample_s;
  logic              final_s;
  logic [DATA_W-1:0] rx_next_s;

  assign accept_s  = cmd_valid_i && ready_r;
  assign div_sel_s = accept_s ? cfg_div_i : div_r;
  // Even edge counts are leading edges; cpha picks which edge samples.
  assign sample_s  = (~edge_cnt_r[0]) ^ ctrl_r.mode.cpha;
  assign final_s   = (edge_cnt_r == LAST_EDGE);
  assign rx_next_s = {rx_r[DATA_W-2:0], miso_i};

  spi_clk_div #(
    .DIV_W (DIV_W)
  ) u_clk_div (
    .clk_i   (clk_i),
    .rst_ni  (rst_ni),
    .start_i (accept_s),
    .en_i    (busy_r),
    .div_i   (div_sel_s),
    .tick_o  (tick_s)
  );

  // Transfer sequencer with registered SPI pins and handshake outputs
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_r     <= IDLE;
      ctrl_r      <= '{mode: '{cpol: 1'b0, cpha: 1'b0}, last: 1'b0};
      cs_idx_r    <= {CS_W{1'b0}};
      div_r       <= {DIV_W{1'b0}};
      tx_r        <= {DATA_W{1'b0}};
      rx_r        <= {DATA_W{1'b0}};
      edge_cnt_r  <= EC_ZERO;
      cs_held_r   <= 1'b0;
      gap_setup_r <= 1'b0;
      ready_r     <= 1'b0;
      busy_r      <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_W{1'b0}};
      sclk_r      <= 1'b0;
      mosi_r      <= 1'b0;
      cs_n_r      <= CS_NONE;
    end else begin
      rsp_valid_r <= 1'b0;
      case (state_r)
        IDLE: begin
          if (accept_s) begin
            ctrl_r.mode.cpol <= cfg_cpol_i;
            ctrl_r.mode.cpha <= cfg_cpha_i;
            ctrl_r.last      <= cmd_last_i;
            cs_idx_r         <= cmd_cs_i;
            div_r            <= cfg_div_i;
            tx_r             <= cmd_data_i;
            edge_cnt_r       <= EC_ZERO;
            ready_r          <= 1'b0;
            busy_r           <= 1'b1;
            if (cs_held_r && (cs_idx_r != cmd_cs_i)) begin
              state_r     <= CS_GAP;
              gap_setup_r <= 1'b1;
              cs_held_r   <= 1'b0;
              cs_n_r      <= CS_NONE;
              mosi_r      <= 1'b0;
            end else begin
              state_r <= CS_SETUP;
              cs_n_r  <= cs_decode(cmd_cs_i);
              sclk_r  <= cfg_cpol_i;
              mosi_r  <= cfg_cpha_i ? 1'b0 : cmd_data_i[DATA_W-1];
            end
          end else begin
            ready_r <= 1'b1;
            busy_r  <= 1'b0;
            if (!cs_held_r) begin
              sclk_r <= cfg_cpol_i;
              mosi_r <= 1'b0;
            end else begin
              sclk_r <= sclk_r;
              mosi_r <= mosi_r;
            end
          end
        end
        CS_GAP: begin
          if (tick_s && gap_setup_r) begin
            state_r     <= CS_SETUP;
            gap_setup_r <= 1'b0;
            cs_n_r      <= cs_decode(cs_idx_r);
            sclk_r      <= ctrl_r.mode.cpol;
            mosi_r      <= ctrl_r.mode.cpha ? 1'b0 : tx_r[DATA_W-1];
          end else if (tick_s) begin
            state_r <= IDLE;
            busy_r  <= 1'b0;
            ready_r <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        CS_SETUP: begin
          if (tick_s) begin
            state_r <= SHIFT;
          end else begin
            state_r <= state_r;
          end
        end
        SHIFT: begin
          if (tick_s) begin
            sclk_r     <= ~sclk_r;
            edge_cnt_r <= edge_cnt_r + EC_W'(1'b1);
            if (sample_s) begin
              rx_r <= rx_next_s;
            end else if (!final_s) begin
              // cpha=1 drives the current MSB; cpha=0 already drove it in setup.
              mosi_r <= ctrl_r.mode.cpha ? tx_r[DATA_W-1] : tx_r[DATA_W-2];
              tx_r   <= {tx_r[DATA_W-2:0], 1'b0};
            end else begin
              tx_r <= tx_r;
            end
            if (final_s) begin
              state_r     <= CS_HOLD;
              rsp_valid_r <= 1'b1;
              rsp_data_r  <= sample_s ? rx_next_s : rx_r;
              edge_cnt_r  <= EC_ZERO;
            end else begin
              state_r <= state_r;
            end
          end else begin
            state_r <= state_r;
          end
        end
        CS_HOLD: begin
          if (tick_s && ctrl_r.last) begin
            state_r     <= CS_GAP;
            gap_setup_r <= 1'b0;
            cs_held_r   <= 1'b0;
            cs_n_r      <= CS_NONE;
            mosi_r      <= 1'b0;
          end else if (tick_s) begin
            state_r   <= IDLE;
            cs_held_r <= 1'b1;
            busy_r    <= 1'b0;
            ready_r   <= 1'b1;
          end else begin
            state_r <= state_r;
          end
        end
        default: begin
          state_r   <= IDLE;
          cs_held_r <= 1'b0;
          busy_r    <= 1'b0;
          ready_r   <= 1'b0;
          cs_n_r    <= CS_NONE;
          mosi_r    <= 1'b0;
        end
      endcase
    end
  end

  assign cmd_ready_o = ready_r;
  assign busy_o      = busy_r;
  assign rsp_valid_o = rsp_valid_r;
  assign rsp_data_o  = rsp_data_r;
  assign sclk_o      = sclk_r;
  assign mosi_o      = mosi_r;
  assign cs_no       = cs_n_r;

endmodule
